pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the saturating stall and flush performance counters.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cur_pc  input  32  current PC register value.
REQ-006 imem_ready  input  1  instruction memory returned data for the current fetch this cycle.
REQ-007 load_use  input  1  decode-stage load-use hazard detected.
REQ-008 br_taken  input  1  EX-stage branch/jump resolved taken.
REQ-009 br_target  input  32  EX-stage redirect address.
REQ-010 next_pc  output  32  value presented to the PC register.
REQ-011 pc_stall  output  1  PC register hold.
REQ-012 ifid_stall  output  1  IF/ID register hold.
REQ-013 ifid_flush  output  1  IF/ID bubble insert.
REQ-014 idex_flush  output  1  ID/EX bubble insert.
REQ-015 imem_req  output  1  fetch request to instruction memory.
REQ-016 misalign  output  1  sticky: a taken redirect had br_target[1:0] != 0.
REQ-017 stall_cnt, flush_cnt  output  CNT_W each  saturating counts of pc_stall cycles and redirect events.

Function
REQ-018 FSM states: BOOT, FETCH, WAIT_MEM, REDIR_PEND; encoding is free.
REQ-019 BOOT: one cycle after reset release; next_pc=RESET_VECTOR, pc_stall=0, imem_req=0, ifid_flush=1; -> FETCH.
REQ-020 FETCH, imem_ready=1, no hazard: next_pc=cur_pc+4 (mod 2^32, wrap 32'hFFFF_FFFC->0), imem_req=1, no stall/flush; stay FETCH.
REQ-021 FETCH, imem_ready=0, br_taken=0: pc_stall=1, ifid_stall=1, next_pc=cur_pc; -> WAIT_MEM.
REQ-022 br_taken in FETCH or WAIT_MEM with imem_ready=1: next_pc={br_target[31:2],2'b00}, ifid_flush=1, idex_flush=1, pc_stall=0; -> FETCH; same-cycle combinational, zero added latency.
REQ-023 br_taken with imem_ready=0: latch aligned target into internal register, pc_stall=1, ifid_flush=1, idex_flush=1; -> REDIR_PEND.
REQ-024 REDIR_PEND: hold pc_stall=1, ifid_flush=1; on imem_ready=1 drive next_pc=latched target, pc_stall=0; -> FETCH; further br_taken here overwrites the latched target.
REQ-025 load_use (no br_taken), imem_ready=1: pc_stall=1, ifid_stall=1, idex_flush=1, next_pc=cur_pc, exactly one cycle; state stays FETCH.
REQ-026 Priority, simultaneous events: br_taken > load_use > imem wait; load_use ignored when br_taken=1.
REQ-027 WAIT_MEM, imem_ready=1, no br_taken: resume per REQ-020/025; -> FETCH.
REQ-028 imem_req=1 in FETCH, WAIT_MEM, REDIR_PEND; 0 only in BOOT.
REQ-029 misalign sets on any accepted redirect with br_target[1:0]!=0; cleared only by reset.
REQ-030 stall_cnt +1 per cycle pc_stall=1; flush_cnt +1 per accepted br_taken; both saturate at all-ones, never wrap.
REQ-031 All outputs except counters/misalign are combinational from state and inputs; no output X after reset.

Reset
REQ-032 rst=1 forces state BOOT, latched target=RESET_VECTOR, misalign=0, counters=0, asynchronously.
REQ-033 During rst: next_pc=RESET_VECTOR, pc_stall=1, ifid_flush=1, idex_flush=1, imem_req=0.
REQ-034 rst asserted mid-WAIT_MEM or REDIR_PEND discards pending redirect; first fetch after release is RESET_VECTOR.

Structure
REQ-035 Shared package pc_pkg holds the state enum, PC_INC=32'd4, RESET_VECTOR default.
REQ-036 One sub-module sat_counter (parameter CNT_W; inc, rst, clk; count) instantiated twice.

Verification
REQ-037 Reset release, imem_ready=1: next_pc sequence 0,4,8,12; stall_cnt=0.
REQ-038 cur_pc=0x10, br_taken=1, br_target=0x203, imem_ready=1: next_pc=0x200, both flushes 1, misalign=1, flush_cnt=1.
REQ-039 cur_pc=0x20, load_use=1 and br_taken=1 (target 0x80) same cycle: next_pc=0x80, no IF/ID stall.
REQ-040 cur_pc=0x40, imem_ready=0 3 cycles, br_taken pulse (target 0x100) cycle 2: REDIR_PEND, pc_stall 1 for 3 cycles, next_pc=0x100 when ready, stall_cnt=3.
REQ-041 CNT_W=4, continuous imem_ready=0 for 20 cycles: stall_cnt saturates at 15.
REQ-042 rst pulsed during REDIR_PEND (target 0x300): after release next_pc=0, target discarded, counters 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC sequencing block.
package pc_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_WAIT_MEM,
        ST_REDIR_PEND
    } seq_state_e;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection and pipeline stall/flush control for the fetch stage,
// with sticky misalignment flag and saturating stall/redirect counters.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     CNT_W        = 16,
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  cur_pc,
    input  logic             imem_ready,
    input  logic             load_use,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    output logic [XLEN-1:0]  next_pc,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             imem_req,
    output logic             misalign,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    seq_state_e      state_q;
    seq_state_e      state_d;
    logic [XLEN-1:0] redir_tgt_q;
    logic [XLEN-1:0] redir_tgt_d;
    logic            misalign_q;
    logic            redir_accept;
    logic [XLEN-1:0] br_tgt_al;

    assign br_tgt_al = align_word(br_target);
    assign misalign  = misalign_q;

    // State, pending redirect target and sticky misalign flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            redir_tgt_q <= RESET_VECTOR;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            redir_tgt_q <= redir_tgt_d;
            if (redir_accept && (br_target[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
        end
    end

    // Next-state and control outputs; priority is redirect > load-use > memory wait.
    always_comb begin
        state_d      = state_q;
        redir_tgt_d  = redir_tgt_q;
        next_pc      = cur_pc;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        imem_req     = 1'b1;
        redir_accept = 1'b0;

        if (rst) begin
            next_pc    = RESET_VECTOR;
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            imem_req   = 1'b0;
            state_d    = ST_BOOT;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    next_pc    = RESET_VECTOR;
                    imem_req   = 1'b0;
                    ifid_flush = 1'b1;
                    state_d    = ST_FETCH;
                end

                ST_FETCH, ST_WAIT_MEM: begin
                    if (br_taken) begin
                        redir_accept = 1'b1;
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                        if (imem_ready) begin
                            next_pc = br_tgt_al;
                            state_d = ST_FETCH;
                        end else begin
                            pc_stall    = 1'b1;
                            redir_tgt_d = br_tgt_al;
                            state_d     = ST_REDIR_PEND;
                        end
                    end else if (imem_ready) begin
                        if (load_use) begin
                            pc_stall   = 1'b1;
                            ifid_stall = 1'b1;
                            idex_flush = 1'b1;
                        end else begin
                            next_pc = cur_pc + PC_INC;
                        end
                        state_d = ST_FETCH;
                    end else begin
                        // Fetch outstanding; a concurrent load-use still needs its bubble.
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = load_use;
                        state_d    = ST_WAIT_MEM;
                    end
                end

                ST_REDIR_PEND: begin
                    ifid_flush = 1'b1;
                    if (br_taken) begin
                        redir_accept = 1'b1;
                        idex_flush   = 1'b1;
                        if (imem_ready) begin
                            next_pc = br_tgt_al;
                            state_d = ST_FETCH;
                        end else begin
                            pc_stall    = 1'b1;
                            redir_tgt_d = br_tgt_al;
                        end
                    end else if (imem_ready) begin
                        next_pc = redir_tgt_q;
                        state_d = ST_FETCH;
                    end else begin
                        pc_stall = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_stall),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redir_accept),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer, plus a narrow-counter instance for saturation.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cur_pc;
    logic        imem_ready;
    logic        load_use;
    logic        br_taken;
    logic [31:0] br_target;

    logic [31:0] next_pc;
    logic        pc_stall, ifid_stall, ifid_flush, idex_flush, imem_req, misalign;
    logic [15:0] stall_cnt, flush_cnt;

    logic [31:0] n_next_pc;
    logic        n_pc_stall, n_ifid_stall, n_ifid_flush, n_idex_flush, n_imem_req, n_misalign;
    logic [3:0]  n_stall_cnt, n_flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.CNT_W(16), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .cur_pc     (cur_pc),
        .imem_ready (imem_ready),
        .load_use   (load_use),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .next_pc    (next_pc),
        .pc_stall   (pc_stall),
        .ifid_stall (ifid_stall),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .imem_req   (imem_req),
        .misalign   (misalign),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    pc_sequencer #(.CNT_W(4), .RESET_VECTOR(32'h0000_0000)) dut_n4 (
        .clk        (clk),
        .rst        (rst),
        .cur_pc     (cur_pc),
        .imem_ready (imem_ready),
        .load_use   (load_use),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .next_pc    (n_next_pc),
        .pc_stall   (n_pc_stall),
        .ifid_stall (n_ifid_stall),
        .ifid_flush (n_ifid_flush),
        .idex_flush (n_idex_flush),
        .imem_req   (n_imem_req),
        .misalign   (n_misalign),
        .stall_cnt  (n_stall_cnt),
        .flush_cnt  (n_flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic lu, input logic br,
                         input logic [31:0] tgt, input logic [31:0] pc);
        imem_ready = rdy;
        load_use   = lu;
        br_taken   = br;
        br_target  = tgt;
        cur_pc     = pc;
        #1;
    endtask

    // Pulse reset for one edge, then pass through BOOT into FETCH.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] seq_exp [4];
        seq_exp[0] = 32'h0; seq_exp[1] = 32'h4; seq_exp[2] = 32'h8; seq_exp[3] = 32'hC;

        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("rst_next_pc",    next_pc,    32'h0);
        check_eq("rst_pc_stall",   32'(pc_stall),   32'd1);
        check_eq("rst_ifid_flush", 32'(ifid_flush), 32'd1);
        check_eq("rst_idex_flush", 32'(idex_flush), 32'd1);
        check_eq("rst_imem_req",   32'(imem_req),   32'd0);
        tick();
        check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check_eq("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        check_eq("rst_misalign",  32'(misalign),  32'd0);

        // Reset release: BOOT then linear fetch.
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("boot_next_pc",    next_pc, seq_exp[0]);
        check_eq("boot_imem_req",   32'(imem_req),   32'd0);
        check_eq("boot_pc_stall",   32'(pc_stall),   32'd0);
        check_eq("boot_ifid_flush", 32'(ifid_flush), 32'd1);
        tick();
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, seq_exp[i-1]);
            check_eq($sformatf("seq_next_pc_%0d", i), next_pc, seq_exp[i]);
            check_eq($sformatf("seq_imem_req_%0d", i), 32'(imem_req), 32'd1);
            tick();
        end
        check_eq("seq_stall_cnt", 32'(stall_cnt), 32'd0);

        // Taken branch with misaligned target, memory ready.
        drive(1'b1, 1'b0, 1'b1, 32'h203, 32'h10);
        check_eq("br_next_pc",    next_pc, 32'h200);
        check_eq("br_ifid_flush", 32'(ifid_flush), 32'd1);
        check_eq("br_idex_flush", 32'(idex_flush), 32'd1);
        check_eq("br_pc_stall",   32'(pc_stall),   32'd0);
        tick();
        check_eq("br_misalign",  32'(misalign),  32'd1);
        check_eq("br_flush_cnt", 32'(flush_cnt), 32'd1);

        // Branch wins over load-use in the same cycle.
        drive(1'b1, 1'b1, 1'b1, 32'h80, 32'h20);
        check_eq("prio_next_pc",    next_pc, 32'h80);
        check_eq("prio_ifid_stall", 32'(ifid_stall), 32'd0);
        check_eq("prio_pc_stall",   32'(pc_stall),   32'd0);
        tick();
        check_eq("prio_flush_cnt", 32'(flush_cnt), 32'd2);

        // Load-use stall alone, then resume.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h24);
        check_eq("lu_next_pc",    next_pc, 32'h24);
        check_eq("lu_pc_stall",   32'(pc_stall),   32'd1);
        check_eq("lu_ifid_stall", 32'(ifid_stall), 32'd1);
        check_eq("lu_idex_flush", 32'(idex_flush), 32'd1);
        check_eq("lu_ifid_flush", 32'(ifid_flush), 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h24);
        check_eq("lu_resume_next_pc", next_pc, 32'h28);
        check_eq("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // PC increment wraps at the top of the address space.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
        check_eq("wrap_next_pc", next_pc, 32'h0);
        tick();

        // Memory wait, redirect arrives while waiting, then memory returns.
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h40);
        check_eq("wait_pc_stall", 32'(pc_stall), 32'd1);
        check_eq("wait_next_pc",  next_pc, 32'h40);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h100, 32'h40);
        check_eq("pend_in_pc_stall",   32'(pc_stall),   32'd1);
        check_eq("pend_in_idex_flush", 32'(idex_flush), 32'd1);
        check_eq("pend_in_ifid_flush", 32'(ifid_flush), 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h40);
        check_eq("pend_hold_pc_stall",   32'(pc_stall),   32'd1);
        check_eq("pend_hold_ifid_flush", 32'(ifid_flush), 32'd1);
        check_eq("pend_hold_imem_req",   32'(imem_req),   32'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h40);
        check_eq("pend_done_next_pc",  next_pc, 32'h100);
        check_eq("pend_done_pc_stall", 32'(pc_stall), 32'd0);
        tick();
        check_eq("pend_stall_cnt", 32'(stall_cnt), 32'd3);
        check_eq("pend_flush_cnt", 32'(flush_cnt), 32'd1);

        // A second redirect while pending replaces the latched target.
        drive(1'b0, 1'b0, 1'b1, 32'h500, 32'h104);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h602, 32'h104);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h104);
        check_eq("overwrite_next_pc", next_pc, 32'h600);
        tick();
        check_eq("overwrite_misalign", 32'(misalign), 32'd1);

        // Reset in the middle of a pending redirect discards it.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h300, 32'h50);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h50);
        check_eq("pre_rst_flush_cnt", 32'(flush_cnt), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_flush_cnt", 32'(flush_cnt), 32'd0);
        check_eq("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check_eq("async_rst_misalign",  32'(misalign),  32'd0);
        check_eq("async_rst_next_pc",   next_pc, 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h50);
        check_eq("post_rst_boot_next_pc", next_pc, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("post_rst_fetch_next_pc", next_pc, 32'h4);
        tick();

        // Long memory wait: 16-bit counter counts on, 4-bit counter sticks at 15.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h80);
            tick();
            if (i == 14) begin
                check_eq("sat4_at_15", 32'(n_stall_cnt), 32'd15);
            end
        end
        check_eq("sat4_final", 32'(n_stall_cnt), 32'd15);
        check_eq("sat16_final", 32'(stall_cnt), 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
